// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// Holds the qualification FSM state encoding and the default stability window.
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 4;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous switch level into the clk domain.
// Both flops clear on synchronous reset so the debouncer restarts from a known low level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a bouncy switch level: a change is accepted only after STABLE_CYCLES consecutive
// identical synchronized samples; a_out, rise and fall are all registered.
//
// Handshake: none. raw_in is a free-running level. a_out is a level; rise and fall are
// single-cycle pulses that are high in the same cycle in which a_out first shows its new value.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   raw_in,
    output logic   a_out,
    output logic   rise,
    output logic   fall,
    output state_e dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_sync_q;
    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_accept_rise;
    logic             w_accept_fall;
    logic             r_a_out;
    logic             r_rise;
    logic             r_fall;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (w_sync_q)
    );

    // The counter holds the number of agreeing samples seen so far in a wait state;
    // it is cleared on every accept or reject, so it never passes CNT_LAST.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_accept_rise = 1'b0;
        w_accept_fall = 1'b0;
        case (r_state)
            LOW: begin
                if (w_sync_q) begin
                    w_next_state = RISE_WAIT;
                    w_next_cnt   = CNT_ONE;
                end
            end
            RISE_WAIT: begin
                if (!w_sync_q) begin
                    w_next_state = LOW;
                    w_next_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state  = HIGH;
                    w_next_cnt    = '0;
                    w_accept_rise = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!w_sync_q) begin
                    w_next_state = FALL_WAIT;
                    w_next_cnt   = CNT_ONE;
                end
            end
            FALL_WAIT: begin
                if (w_sync_q) begin
                    w_next_state = HIGH;
                    w_next_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state  = LOW;
                    w_next_cnt    = '0;
                    w_accept_fall = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = LOW;
                w_next_cnt   = '0;
            end
        endcase
    end

    // a_out is registered from the next-state decode so it always matches r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_a_out <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_a_out <= (w_next_state == HIGH) || (w_next_state == FALL_WAIT);
            r_rise  <= w_accept_rise;
            r_fall  <= w_accept_fall;
        end
    end

    assign a_out     = r_a_out;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign dbg_state = r_state;

endmodule
